// File: rtl/crc8_check.sv
// Bit-serial CRC-8 checker: latches a data word and its received CRC, recomputes
// the CRC MSB-first one bit per clock, then flags match/mismatch and counts errors.
`timescale 1ns/1ps
module crc8_check #(
    parameter int         DATA_W = 64,
    parameter logic [7:0] POLY   = 8'h07,
    parameter logic [7:0] INIT   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic [7:0]        crc_i,
    input  logic              chk_start,
    input  logic              clr_cnt,
    output logic              chk_busy,
    output logic              chk_vld,
    output logic              crc_ok,
    output logic [7:0]        crc_calc,
    output logic [15:0]       err_cnt
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CMP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [7:0]        ref_crc;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (chk_start) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lfsr_nxt = {lfsr[6:0], 1'b0} ^ ((lfsr[7] ^ sreg[DATA_W-1]) ? POLY : 8'h00);
    end

    assign mismatch = (lfsr != ref_crc);
    assign chk_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data shift register is a plain register, not a memory, so it is cleared too.
            sreg     <= '0;
            ref_crc  <= 8'h00;
            lfsr     <= 8'h00;
            cnt      <= '0;
            chk_vld  <= 1'b0;
            crc_ok   <= 1'b0;
            crc_calc <= 8'h00;
            err_cnt  <= 16'h0000;
        end else begin
            chk_vld <= (state == CMP);

            case (state)
                IDLE: begin
                    if (chk_start) begin
                        sreg    <= din;
                        ref_crc <= crc_i;
                        lfsr    <= INIT;
                        cnt     <= CNT_W'(DATA_W - 1);
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_nxt;
                    sreg <= {sreg[DATA_W-2:0], 1'b0};
                    cnt  <= cnt - CNT_W'(1);
                end
                CMP: begin
                    crc_calc <= lfsr;
                    crc_ok   <= ~mismatch;
                end
                default: ;
            endcase

            // A clear on the comparison edge wins over the increment.
            if (clr_cnt) begin
                err_cnt <= 16'h0000;
            end else if ((state == CMP) && mismatch && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_crc8_check.sv
// Self-checking bench for crc8_check: expected results are queued when a start is
// driven and compared (including exact result cycle) when chk_vld fires.
`timescale 1ns/1ps
module tb_crc8_check;

    localparam int DW = 64;

    typedef struct {
        logic        ok;
        logic [7:0]  calc;
        logic [15:0] err;
        int unsigned cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic [7:0]    crc_i;
    logic          chk_start;
    logic          clr_cnt;
    logic          chk_busy;
    logic          chk_vld;
    logic          crc_ok;
    logic [7:0]    crc_calc;
    logic [15:0]   err_cnt;

    exp_t          sb[$];
    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [15:0]   exp_err = 16'h0000;

    crc8_check #(.DATA_W(DW), .POLY(8'h07), .INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .crc_i     (crc_i),
        .chk_start (chk_start),
        .clr_cnt   (clr_cnt),
        .chk_busy  (chk_busy),
        .chk_vld   (chk_vld),
        .crc_ok    (crc_ok),
        .crc_calc  (crc_calc),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [DW-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Scoreboard consumer: every chk_vld must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && chk_vld) begin
            check("busy_at_vld", chk_busy, 0);
            if (sb.size() == 0) begin
                check("unexpected_vld", chk_vld, 0);
            end else begin
                e = sb.pop_front();
                check("crc_ok", crc_ok, e.ok);
                check("crc_calc", crc_calc, e.calc);
                check("err_cnt", err_cnt, e.err);
                check("vld_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge when the DUT is idle or pulsing chk_vld.
    task automatic do_start(input logic [DW-1:0] d, input logic [7:0] c,
                            input logic [7:0] good, input bit clr_at_cmp);
        exp_t e;
        chk_start = 1'b1;
        din       = d;
        crc_i     = c;
        e.ok      = (c == good);
        e.calc    = good;
        if (clr_at_cmp)
            exp_err = 16'h0000;
        else if (!e.ok && exp_err != 16'hFFFF)
            exp_err = exp_err + 16'd1;
        e.err = exp_err;
        e.cyc = cyc + DW + 2;
        sb.push_back(e);
        @(negedge clk);
        chk_start = 1'b0;
        din       = {$urandom, $urandom};
        crc_i     = 8'($urandom);
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!chk_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!chk_vld) begin
            check({tag, "_timeout"}, chk_vld, 1);
            sb.delete();
        end
    endtask

    task automatic run(input string tag, input logic [DW-1:0] d, input logic [7:0] c,
                       input logic [7:0] good);
        do_start(d, c, good, 1'b0);
        wait_vld(tag);
        @(negedge clk);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_busy"}, chk_busy, 0);
        check({pfx, "_vld"}, chk_vld, 0);
        check({pfx, "_ok"}, crc_ok, 0);
        check({pfx, "_calc"}, crc_calc, 0);
        check({pfx, "_err"}, err_cnt, 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [7:0]    g;
        int unsigned   t1;

        rst       = 1'b1;
        din       = '0;
        crc_i     = 8'h00;
        chk_start = 1'b0;
        clr_cnt   = 1'b0;
        repeat (5) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Known vectors
        run("kv1", 64'h0000_0000_0000_0001, 8'h07, 8'h07);
        run("kv80", 64'h80, 8'h89, 8'h89);
        run("kv100", 64'h0100, 8'h15, 8'h15);
        run("kv0", 64'h0, 8'h00, 8'h00);

        // Mismatch: err_cnt 0 -> 1
        run("mism", 64'h01, 8'h06, 8'h07);

        // Busy rejection: second start 10 cycles in is ignored
        d = 64'h1234_5678_9ABC_DEF0;
        g = crc_model(d);
        do_start(d, g, g, 1'b0);
        repeat (9) @(negedge clk);
        chk_start = 1'b1;
        din       = 64'hFFFF_0000_FFFF_0000;
        crc_i     = 8'h5A;
        @(negedge clk);
        chk_start = 1'b0;
        wait_vld("busy_rej");
        repeat (80) @(negedge clk);
        check("busy_rej_idle", chk_busy, 0);

        // Back-to-back: new start in the chk_vld cycle
        d = 64'hA5A5_5A5A_0F0F_F0F0;
        do_start(d, crc_model(d), crc_model(d), 1'b0);
        wait_vld("b2b_a");
        t1 = cyc;
        d  = 64'h0123_4567_89AB_CDEF;
        do_start(d, 8'h00, crc_model(d), 1'b0);
        wait_vld("b2b_b");
        check("b2b_spacing", cyc - t1, DW + 2);
        @(negedge clk);

        // Reset mid-run: aborted check produces no chk_vld
        d = 64'hDEAD_BEEF_CAFE_F00D;
        do_start(d, crc_model(d), crc_model(d), 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        exp_err = 16'h0000;
        repeat (5) @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("abort_idle", chk_busy, 0);
        check("abort_err", err_cnt, exp_err);

        // Saturation: preload near full scale, then two mismatches and a match
        force dut.err_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt;
        exp_err = 16'hFFFE;
        @(negedge clk);
        check("preload", err_cnt, exp_err);
        run("sat1", 64'h01, 8'h00, 8'h07);
        run("sat2", 64'h01, 8'h00, 8'h07);
        run("sat_hold", 64'h01, 8'h07, 8'h07);

        // clr_cnt on the same edge as a mismatch result
        do_start(64'h80, 8'h00, 8'h89, 1'b1);
        repeat (DW) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        wait_vld("clr_mism");
        @(negedge clk);
        check("clr_err", err_cnt, 0);

        // Random regression, chained back-to-back
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom};
            g = crc_model(d);
            do_start(d, (i % 2 == 0) ? g : 8'($urandom), g, 1'b0);
            wait_vld("rand");
        end
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("final_err", err_cnt, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
